// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle signed restoring divider, one quotient bit per clock.
// Optional remainder output: define SEQ_DIVIDER_REMAINDER_EN.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
`ifdef SEQ_DIVIDER_REMAINDER_EN
    output logic             busy,
    output logic [WIDTH-1:0] data_remainder
`else
    output logic             busy
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] bmag;
    logic             sign_q;
    logic             div0;
`ifdef SEQ_DIVIDER_REMAINDER_EN
    logic             sign_r;
`endif

    logic             load;
    logic             step;
    logic             finish;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start pulse wins from any state; in DONE the finishing result is still written.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (ctrl_div) state_next = S_RUN;
            S_RUN:   if (ctrl_div) state_next = S_RUN;
                     else if (cnt == '0) state_next = S_DONE;
            S_DONE:  state_next = ctrl_div ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != S_IDLE);
        load   = ctrl_div;
        step   = (state == S_RUN) && !ctrl_div;
        finish = (state == S_DONE);
    end

    // Magnitudes are unsigned WIDTH-bit, so the most-negative operand keeps all its bits.
    always_comb begin
        a_mag   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        b_mag   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        shifted = {rem, dvd[WIDTH-1]};
        trial   = shifted - {1'b0, bmag};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt            <= '0;
            dvd            <= '0;
            rem            <= '0;
            bmag           <= '0;
            sign_q         <= 1'b0;
            div0           <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
`ifdef SEQ_DIVIDER_REMAINDER_EN
            sign_r         <= 1'b0;
            data_remainder <= '0;
`endif
        end else begin
            data_resultRDY <= finish;
            if (finish) begin
                data_result    <= div0 ? '0 : (sign_q ? -dvd : dvd);
                data_exception <= div0;
`ifdef SEQ_DIVIDER_REMAINDER_EN
                data_remainder <= div0 ? '0 : (sign_r ? -rem : rem);
`endif
            end
            if (load) begin
                dvd    <= a_mag;
                bmag   <= b_mag;
                rem    <= '0;
                cnt    <= CW'(WIDTH - 1);
                sign_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div0   <= (data_operandB == '0);
`ifdef SEQ_DIVIDER_REMAINDER_EN
                sign_r <= data_operandA[WIDTH-1];
`endif
            end else if (step) begin
                // Quotient bits shift into the vacated low end of the dividend register.
                if (!trial[WIDTH]) begin
                    rem <= trial[WIDTH-1:0];
                    dvd <= {dvd[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= shifted[WIDTH-1:0];
                    dvd <= {dvd[WIDTH-2:0], 1'b0};
                end
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider with directed vectors.
module tb_seq_divider;

    localparam int W = 32;

    logic         clock;
    logic         reset_n;
    logic         ctrl_div;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;
`ifdef SEQ_DIVIDER_REMAINDER_EN
    logic [W-1:0] data_remainder;
`endif

    seq_divider #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
`ifdef SEQ_DIVIDER_REMAINDER_EN
        .busy           (busy),
        .data_remainder (data_remainder)
`else
        .busy           (busy)
`endif
    );

    typedef struct {
        logic [W-1:0] q;
        logic         exc;
        logic [W-1:0] r;
        int           t_rdy;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 64'(cyc), 64'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 64'(data_result), 64'(e.q));
                chk("exception", 64'(data_exception), 64'(e.exc));
                chk("latency", 64'(cyc), 64'(e.t_rdy));
`ifdef SEQ_DIVIDER_REMAINDER_EN
                chk("remainder", 64'(data_remainder), 64'(e.r));
`endif
            end
        end
    end

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input bit push,
                         input logic [W-1:0] q, input logic exc, input logic [W-1:0] r);
        exp_t e;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_div      = 1'b1;
        if (push) begin
            e.q = q; e.exc = exc; e.r = r;
            e.t_rdy = cyc + 1 + W + 1;
            sb.push_back(e);
        end
        @(negedge clock);
        ctrl_div = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            chk("timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clock);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] q, input logic exc, input logic [W-1:0] r);
        start(a, b, 1'b1, q, exc, r);
        wait_done();
    endtask

    initial begin
        reset_n       = 1'b0;
        ctrl_div      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        chk("reset_result", 64'(data_result), 64'd0);
        chk("reset_exc", 64'(data_exception), 64'd0);
        chk("reset_rdy", 64'(data_resultRDY), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        op(32'd100, 32'd7, 32'd14, 1'b0, 32'd2);
        op(-32'sd100, 32'd7, -32'sd14, 1'b0, -32'sd2);
        op(32'd100, -32'sd7, -32'sd14, 1'b0, 32'd2);
        op(-32'sd100, -32'sd7, 32'd14, 1'b0, -32'sd2);
        op(32'd7, 32'd100, 32'd0, 1'b0, 32'd7);
        op(-32'sd7, 32'd2, -32'sd3, 1'b0, -32'sd1);
        op(32'd5, 32'd0, 32'd0, 1'b1, 32'd0);
        chk("exc_held", 64'(data_exception), 64'd1);
        chk("busy_after", 64'(busy), 64'd0);
        op(32'd9, 32'd3, 32'd3, 1'b0, 32'd0);
        op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'd0);
        op(32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 32'd0);

        // Restart while busy: only the second operation may report.
        start(32'd1000, 32'd10, 1'b0, '0, 1'b0, '0);
        repeat (8) @(negedge clock);
        chk("busy_run", 64'(busy), 64'd1);
        start(32'd81, 32'd9, 1'b1, 32'd9, 1'b0, 32'd0);
        wait_done();

        // Asynchronous reset mid-operation clears outputs at once and suppresses ready.
        start(32'd50, 32'd5, 1'b0, '0, 1'b0, '0);
        repeat (13) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("areset_result", 64'(data_result), 64'd0);
        chk("areset_busy", 64'(busy), 64'd0);
        chk("areset_rdy", 64'(data_resultRDY), 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        op(32'd50, 32'd5, 32'd10, 1'b0, 32'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
